// File: rtl/pong_pkg.sv
// Shared Pong definitions: match states, screen/paddle geometry and parameter defaults.
package pong_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SERVE = 3'd1,
      ST_PLAY  = 3'd2,
      ST_POINT = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   localparam int SCREEN_W  = 32'd640;
   localparam int SCREEN_H  = 32'd480;
   localparam int BALL_SIZE = 32'd10;
   localparam int PADDLE_W  = 32'd10;
   localparam int PADDLE_H  = 32'd60;

   localparam int TICK_DIV_DEF    = 32'd65536;
   localparam int WIN_SCORE_DEF   = 32'd11;
   localparam int SERVE_TICKS_DEF = 32'd60;
   localparam int SCORE_W_DEF     = 32'd4;

   // Paddles may move during SERVE and PLAY; the ball only during PLAY.
   function automatic logic in_rally(input state_e s);
      return (s == ST_SERVE) || (s == ST_PLAY);
   endfunction

endpackage

// File: rtl/pong_match_ctrl_if.sv
// Match controller bus: player/datapath inputs and game-state outputs.
// pause_btn/paused exist only when PONG_PAUSE_EN is defined.
interface pong_match_ctrl_if #(
   parameter int SCORE_W = 4
);
   logic               start;
   logic               miss_left;
   logic               miss_right;
   logic               tick;
   logic               ball_move_en;
   logic               paddle_move_en;
   logic               ball_load;
   logic               serve_dir;
   logic [SCORE_W-1:0] score_left;
   logic [SCORE_W-1:0] score_right;
   logic [2:0]         state;
   logic               winner;
`ifdef PONG_PAUSE_EN
   logic               pause_btn;
   logic               paused;

   modport master (
      input  start, miss_left, miss_right, pause_btn,
      output tick, ball_move_en, paddle_move_en, ball_load, serve_dir,
             score_left, score_right, state, winner, paused
   );
   modport slave (
      output start, miss_left, miss_right, pause_btn,
      input  tick, ball_move_en, paddle_move_en, ball_load, serve_dir,
             score_left, score_right, state, winner, paused
   );
`else
   modport master (
      input  start, miss_left, miss_right,
      output tick, ball_move_en, paddle_move_en, ball_load, serve_dir,
             score_left, score_right, state, winner
   );
   modport slave (
      output start, miss_left, miss_right,
      input  tick, ball_move_en, paddle_move_en, ball_load, serve_dir,
             score_left, score_right, state, winner
   );
`endif
endinterface

// File: rtl/pong_tick_gen.sv
// Movement-tick generator: registered one-cycle pulse every TICK_DIV clk cycles.
module pong_tick_gen #(
   parameter int TICK_DIV = 65536
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);
   localparam int               CNT_W    = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             tick_r;

   // Modulo counter; the pulse is registered on the terminal count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r  <= '0;
         tick_r <= 1'b0;
      end else begin
         tick_r <= (cnt_r == CNT_LAST);
         if (cnt_r == CNT_LAST) begin
            cnt_r <= '0;
         end else begin
            cnt_r <= cnt_r + CNT_W'(1'b1);
         end
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: game FSM, scores, serve control and movement enables.
// Optional pause feature enabled by defining PONG_PAUSE_EN.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int TICK_DIV    = TICK_DIV_DEF,
   parameter int SERVE_TICKS = SERVE_TICKS_DEF,
   parameter int WIN_SCORE   = WIN_SCORE_DEF,
   parameter int SCORE_W     = SCORE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   pong_match_ctrl_if.master bus
);
   localparam int                 SC_W       = $clog2(SERVE_TICKS + 1);
   localparam logic [SC_W-1:0]    SERVE_LAST = SC_W'(SERVE_TICKS);
   localparam logic [SCORE_W-1:0] WIN_VAL    = SCORE_W'(WIN_SCORE);

   state_e             state_r, state_nx;
   logic [SC_W-1:0]    serve_cnt_r, serve_cnt_nx;
   logic               ball_load_r, ball_load_nx;
   logic               serve_dir_r, serve_dir_nx;
   logic [SCORE_W-1:0] score_l_r, score_l_nx;
   logic [SCORE_W-1:0] score_r_r, score_r_nx;
   logic               winner_r, winner_nx;
   logic               tick_s;
   logic               paused_s;

   pong_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_s)
   );

   // Match state and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         serve_cnt_r <= '0;
         ball_load_r <= 1'b0;
         serve_dir_r <= 1'b1;
         score_l_r   <= '0;
         score_r_r   <= '0;
         winner_r    <= 1'b0;
      end else begin
         state_r     <= state_nx;
         serve_cnt_r <= serve_cnt_nx;
         ball_load_r <= ball_load_nx;
         serve_dir_r <= serve_dir_nx;
         score_l_r   <= score_l_nx;
         score_r_r   <= score_r_nx;
         winner_r    <= winner_nx;
      end
   end

   // Next-state logic; every path into SERVE clears the serve counter and requests a recentre.
   always_comb begin
      state_nx     = state_r;
      serve_cnt_nx = serve_cnt_r;
      ball_load_nx = 1'b0;
      serve_dir_nx = serve_dir_r;
      score_l_nx   = score_l_r;
      score_r_nx   = score_r_r;
      winner_nx    = winner_r;
      case (state_r)
         ST_IDLE: begin
            score_l_nx   = '0;
            score_r_nx   = '0;
            serve_dir_nx = 1'b1;
            if (bus.start) begin
               state_nx     = ST_SERVE;
               serve_cnt_nx = '0;
               ball_load_nx = 1'b1;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         ST_SERVE: begin
            if (paused_s) begin
               state_nx = ST_SERVE;
            end else if (serve_cnt_r == SERVE_LAST) begin
               state_nx = ST_PLAY;
            end else if (tick_s) begin
               serve_cnt_nx = serve_cnt_r + SC_W'(1'b1);
            end else begin
               state_nx = ST_SERVE;
            end
         end
         ST_PLAY: begin
            // A double miss replays the point without scoring.
            if (paused_s) begin
               state_nx = ST_PLAY;
            end else if (bus.miss_left && bus.miss_right) begin
               state_nx = ST_POINT;
            end else if (bus.miss_left) begin
               score_r_nx   = score_r_r + SCORE_W'(1'b1);
               serve_dir_nx = 1'b0;
               state_nx     = ST_POINT;
            end else if (bus.miss_right) begin
               score_l_nx   = score_l_r + SCORE_W'(1'b1);
               serve_dir_nx = 1'b1;
               state_nx     = ST_POINT;
            end else begin
               state_nx = ST_PLAY;
            end
         end
         ST_POINT: begin
            if ((score_l_r == WIN_VAL) || (score_r_r == WIN_VAL)) begin
               state_nx  = ST_OVER;
               winner_nx = (score_r_r == WIN_VAL);
            end else begin
               state_nx     = ST_SERVE;
               serve_cnt_nx = '0;
               ball_load_nx = 1'b1;
            end
         end
         ST_OVER: begin
            if (bus.start) begin
               state_nx     = ST_SERVE;
               serve_cnt_nx = '0;
               ball_load_nx = 1'b1;
               serve_dir_nx = 1'b1;
               score_l_nx   = '0;
               score_r_nx   = '0;
            end else begin
               state_nx = ST_OVER;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

`ifdef PONG_PAUSE_EN
   logic pause_q_r;
   logic paused_r, paused_nx;

   // Pause toggles on a button rising edge during a rally and drops when the rally ends.
   always_comb begin
      paused_nx = paused_r;
      if ((state_nx == ST_IDLE) || (state_nx == ST_POINT) || (state_nx == ST_OVER)) begin
         paused_nx = 1'b0;
      end else if (in_rally(state_r) && bus.pause_btn && !pause_q_r) begin
         paused_nx = !paused_r;
      end else begin
         paused_nx = paused_r;
      end
   end

   // Button sample for edge detection and the pause flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pause_q_r <= 1'b0;
         paused_r  <= 1'b0;
      end else begin
         pause_q_r <= bus.pause_btn;
         paused_r  <= paused_nx;
      end
   end

   assign paused_s   = paused_r;
   assign bus.paused = paused_r;
`else
   assign paused_s = 1'b0;
`endif

   assign bus.tick           = tick_s;
   assign bus.ball_move_en   = tick_s && (state_r == ST_PLAY) && !paused_s;
   assign bus.paddle_move_en = tick_s && in_rally(state_r) && !paused_s;
   assign bus.ball_load      = ball_load_r;
   assign bus.serve_dir      = serve_dir_r;
   assign bus.score_left     = score_l_r;
   assign bus.score_right    = score_r_r;
   assign bus.state          = state_r;
   assign bus.winner         = winner_r;

endmodule
